// File: rtl/rst_req_gen_pkg.sv
// rst_req_gen_pkg: FSM state and reset-cause encodings plus counter-width helper for rst_req_gen
package rst_req_gen_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_WDOG = 2'b10,
    CAUSE_SW   = 2'b11
  } cause_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rst_req_gen_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus DEB_CYC stability filter, one-cycle btn_press strobe on accepted press
module btn_debounce
  import rst_req_gen_pkg::*;
#(
  parameter int DEB_CYC = 1024
) (
  input  logic clk,
  input  logic RST_n,
  input  logic btn_n,
  output logic btn_press
);
  localparam int DW = cnt_w(DEB_CYC);
  logic          s1, s2, deb;
  logic [DW-1:0] cnt;
  logic          change, done;
  assign change = s2 != deb;
  assign done   = cnt == DW'(DEB_CYC - 1);
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      deb       <= 1'b1;
      cnt       <= '0;
      btn_press <= 1'b0;
    end else begin
      s1        <= btn_n;
      s2        <= s1;
      btn_press <= change && done && !s2;
      cnt       <= change && !done ? cnt + 1'b1 : '0;
      if (change && done) deb <= s2;
    end
endmodule

// File: rtl/rst_req_gen.sv
// rst_req_gen: button/software/watchdog reset-request pulse generator; watchdog compiled in by RST_REQ_GEN_WDOG_EN
module rst_req_gen
  import rst_req_gen_pkg::*;
#(
  parameter int PULSE_CYC   = 16,
  parameter int HOLDOFF_CYC = 64,
  parameter int DEB_CYC     = 1024,
  parameter int WDOG_CYC    = 1048576
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       btn_n,
  input  logic       sw_rst_req,
  input  logic       wdog_kick,
  output logic       rst_req_n,
  output logic [1:0] rst_cause,
  output logic       busy
);
  localparam int PW = cnt_w(PULSE_CYC);
  localparam int HW = cnt_w(HOLDOFF_CYC);
  state_t        state;
  logic [PW-1:0] p_cnt;
  logic [HW-1:0] h_cnt;
  logic          btn_press, wd_exp;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk       (clk),
    .RST_n     (RST_n),
    .btn_n     (btn_n),
    .btn_press (btn_press)
  );
`ifdef RST_REQ_GEN_WDOG_EN
  localparam int WW = cnt_w(WDOG_CYC);
  logic [WW-1:0] wd_cnt;
  logic          wd_top;
  assign wd_top = wd_cnt == WW'(WDOG_CYC - 1);
  assign wd_exp = wd_top && !wdog_kick;
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) wd_cnt <= '0;
    else        wd_cnt <= state != IDLE || wdog_kick ? '0 : wd_top ? wd_cnt : wd_cnt + 1'b1;
`else
  logic unused_kick;
  assign unused_kick = wdog_kick ^ (WDOG_CYC == 0);
  assign wd_exp      = 1'b0;
`endif
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) begin
      state     <= IDLE;
      rst_req_n <= 1'b1;
      rst_cause <= CAUSE_NONE;
      busy      <= 1'b0;
      p_cnt     <= '0;
      h_cnt     <= '0;
    end else begin
      case (state)
        IDLE:
          if (btn_press || wd_exp || sw_rst_req) begin
            state     <= ASSERT;
            rst_req_n <= 1'b0;
            busy      <= 1'b1;
            p_cnt     <= '0;
            rst_cause <= btn_press ? CAUSE_BTN : wd_exp ? CAUSE_WDOG : CAUSE_SW;
          end
        ASSERT:
          if (p_cnt == PW'(PULSE_CYC - 1)) begin
            state     <= HOLDOFF;
            rst_req_n <= 1'b1;
            h_cnt     <= '0;
          end else p_cnt <= p_cnt + 1'b1;
        HOLDOFF:
          if (h_cnt == HW'(HOLDOFF_CYC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else h_cnt <= h_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
